// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running up-counter: confirms +1 mod 2^WIDTH
// steps, locks after LOCK_CNT good steps, and reports wraps and errors.
module count_seq_checker #(
  parameter int WIDTH       = 3,
  parameter int LOCK_CNT    = 4,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 8,
  parameter int ALLOW_STALL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clr_stats,
  output logic              locked,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_CNT);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       run;

  logic [WIDTH-1:0] next_val;
  logic             good_step;
  logic             wrap_step;
  logic             stall_ok;
  logic             err_inc;
  logic             wrap_inc;

  always_comb begin
    next_val  = prev + WIDTH'(1);
    good_step = (count_in == next_val);
    wrap_step = (prev == MAX_VAL) && (count_in == '0);
    stall_ok  = (ALLOW_STALL != 0) && (count_in == prev);
    // Errors and wraps are only meaningful once the checker trusts the stream.
    err_inc   = in_valid && (state == LOCKED) && !good_step && !stall_ok;
    wrap_inc  = in_valid && (state == LOCKED) && good_step && wrap_step;
  end

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_pulse  <= err_inc;
      wrap_pulse <= wrap_inc;

      if (in_valid) begin
        prev <= count_in;
        case (state)
          IDLE: begin
            run   <= '0;
            state <= SYNC;
          end
          SYNC: begin
            if (good_step) begin
              run <= run + 4'd1;
              if (run + 4'd1 >= LOCK_RUN) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (err_inc) begin
              run    <= '0;
              state  <= SYNC;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      // Clear beats a coincident increment; both counters stick at all-ones.
      if (clr_stats) begin
        err_count  <= '0;
        wrap_count <= '0;
      end else begin
        if (err_inc && (err_count != '1))
          err_count <= err_count + ERR_W'(1);
        if (wrap_inc && (wrap_count != '1))
          wrap_count <= wrap_count + WRAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench: strict checker (ALLOW_STALL=0) and stall-tolerant checker
// (ALLOW_STALL=1) share one directed stimulus stream.
module tb_count_seq_checker;

  typedef struct packed {
    logic       locked;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] count_in = '0;
  logic       clr_stats = 1'b0;

  logic       locked_a, err_pulse_a, wrap_pulse_a;
  logic [7:0] err_count_a, wrap_count_a;
  logic       locked_b, err_pulse_b, wrap_pulse_b;
  logic [7:0] err_count_b, wrap_count_b;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] ea = '0, wa = '0, eb = '0, wb = '0;
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  count_seq_checker #(.ALLOW_STALL(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .clr_stats(clr_stats), .locked(locked_a), .err_pulse(err_pulse_a),
    .wrap_pulse(wrap_pulse_a), .err_count(err_count_a), .wrap_count(wrap_count_a)
  );

  count_seq_checker #(.ALLOW_STALL(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .clr_stats(clr_stats), .locked(locked_b), .err_pulse(err_pulse_b),
    .wrap_pulse(wrap_pulse_b), .err_count(err_count_b), .wrap_count(wrap_count_b)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] next_cnt(input logic [7:0] cur, input logic r,
                                          input logic clr, input logic inc);
    if (r || clr) return 8'd0;
    if (inc && cur != 8'hFF) return cur + 8'd1;
    return cur;
  endfunction

  // One cycle of stimulus plus the hand-stated pulses/lock for both instances.
  task automatic step(input logic r, input logic v, input logic [2:0] c, input logic clr,
                      input logic la, input logic epa, input logic wpa,
                      input logic lb, input logic epb, input logic wpb);
    @(negedge clk);
    reset = r; in_valid = v; count_in = c; clr_stats = clr;
    ea = next_cnt(ea, r, clr, epa);
    wa = next_cnt(wa, r, clr, wpa);
    eb = next_cnt(eb, r, clr, epb);
    wb = next_cnt(wb, r, clr, wpb);
    qa.push_back('{locked: la, err_pulse: epa, wrap_pulse: wpa, err_count: ea, wrap_count: wa});
    qb.push_back('{locked: lb, err_pulse: epb, wrap_pulse: wpb, err_count: eb, wrap_count: wb});
  endtask

  // Identical expectation for both instances.
  task automatic both(input logic v, input logic [2:0] c, input logic l,
                      input logic ep, input logic wp);
    step(1'b0, v, c, 1'b0, l, ep, wp, l, ep, wp);
  endtask

  // Monitor: outputs are presented every cycle; compare 2 ns after the edge.
  initial begin
    exp_t xa, xb;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() != 0 && qb.size() != 0) begin
        xa = qa.pop_front();
        xb = qb.pop_front();
        check("a_locked",     32'(locked_a),     32'(xa.locked));
        check("a_err_pulse",  32'(err_pulse_a),  32'(xa.err_pulse));
        check("a_wrap_pulse", 32'(wrap_pulse_a), 32'(xa.wrap_pulse));
        check("a_err_count",  32'(err_count_a),  32'(xa.err_count));
        check("a_wrap_count", 32'(wrap_count_a), 32'(xa.wrap_count));
        check("b_locked",     32'(locked_b),     32'(xb.locked));
        check("b_err_pulse",  32'(err_pulse_b),  32'(xb.err_pulse));
        check("b_wrap_pulse", 32'(wrap_pulse_b), 32'(xb.wrap_pulse));
        check("b_err_count",  32'(err_count_b),  32'(xb.err_count));
        check("b_wrap_count", 32'(wrap_count_b), 32'(xb.wrap_count));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] p;

    // Reset, then acquire lock on 0,1,2,3,4.
    repeat (3) step(1'b1, 1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0);
    both(1, 3'd0, 0, 0, 0);
    both(1, 3'd1, 0, 0, 0);
    both(1, 3'd2, 0, 0, 0);
    both(1, 3'd3, 0, 0, 0);
    both(1, 3'd4, 1, 0, 0);

    // Wrap while locked.
    both(1, 3'd5, 1, 0, 0);
    both(1, 3'd6, 1, 0, 0);
    both(1, 3'd7, 1, 0, 0);
    both(1, 3'd0, 1, 0, 1);
    both(1, 3'd1, 1, 0, 0);

    // Invalid gaps carrying junk are ignored; 1 -> 2 is still a good step.
    both(0, 3'd7, 1, 0, 0);
    both(0, 3'd5, 1, 0, 0);
    both(1, 3'd2, 1, 0, 0);

    // Upstream reset from 3 to 0 while locked, then reacquire.
    both(1, 3'd3, 1, 0, 0);
    both(1, 3'd0, 0, 1, 0);
    both(1, 3'd1, 0, 0, 0);
    both(1, 3'd2, 0, 0, 0);
    both(1, 3'd3, 0, 0, 0);
    both(1, 3'd4, 1, 0, 0);

    // Repeated sample: error for strict checker, tolerated by the other.
    step(0, 1, 3'd4, 0, 0, 1, 0, 1, 0, 0);
    step(0, 1, 3'd5, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 3'd6, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 3'd7, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 3'd0, 0, 1, 0, 0, 1, 0, 1);

    // Drive both error counters into saturation: error, then four steps to relock.
    p = 3'd0;
    for (int i = 0; i < 256; i++) begin
      both(1, 3'(p + 3'd3), 0, 1, 0);
      both(1, 3'(p + 3'd4), 0, 0, 0);
      both(1, 3'(p + 3'd5), 0, 0, 0);
      both(1, 3'(p + 3'd6), 0, 0, 0);
      both(1, 3'(p + 3'd7), 1, 0, 0);
      p = 3'(p + 3'd7);
    end
    both(0, 3'd0, 1, 0, 0);

    // Clear coinciding with an error: pulse still fires, counters read 0.
    step(0, 1, 3'(p + 3'd3), 1, 0, 1, 0, 0, 1, 0);
    both(1, 3'(p + 3'd4), 0, 0, 0);
    both(1, 3'(p + 3'd5), 0, 0, 0);
    both(1, 3'(p + 3'd6), 0, 0, 0);
    both(1, 3'(p + 3'd7), 1, 0, 0);

    // Reset while locked with a valid sample present.
    step(1, 1, 3'(p + 3'd8), 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_a_drained", 32'(qa.size()), 32'd0);
    check("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
